// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, one bit per clock.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             divop,
  input  logic             signedop,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             hiwrite,
  input  logic             lowrite,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             divzero
);

  localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc;    // mul: {partial product, multiplier}; div: lower half holds dividend/quotient
  logic [WIDTH-1:0]     rem;
  logic [WIDTH-1:0]     opd;    // multiplicand or divisor
  logic                 neg_q;
  logic                 neg_r;

  logic [WIDTH-1:0]     a_abs, b_abs;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next, prod;
  logic [WIDTH:0]       div_shift;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_diff, div_rem, div_quo, quo_fix, rem_fix;

  // Operand magnitudes and single-step datapath for both operations
  always_comb begin
    a_abs     = (signedop && srca[WIDTH-1]) ? -srca : srca;
    b_abs     = (signedop && srcb[WIDTH-1]) ? -srcb : srcb;

    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd} : '0);
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    prod      = neg_q ? -mul_next : mul_next;

    div_shift = {rem, acc[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opd});
    // When div_ge holds the difference is below opd, so W-bit wraparound is exact
    div_diff  = div_shift[WIDTH-1:0] - opd;
    div_rem   = div_ge ? div_diff : div_shift[WIDTH-1:0];
    div_quo   = {acc[WIDTH-2:0], div_ge};
    quo_fix   = neg_q ? -div_quo : div_quo;
    rem_fix   = neg_r ? -div_rem : div_rem;
  end

  // Control FSM, iteration registers and HI/LO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      rem     <= '0;
      opd     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      divzero <= 1'b0;
    end else begin
      done    <= 1'b0;
      divzero <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (hiwrite) hi <= wdata;
          if (lowrite) lo <= wdata;
          if (start) begin
            cnt   <= '0;
            neg_q <= signedop & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
            neg_r <= signedop & srca[WIDTH-1];
            if (!divop) begin
              opd   <= a_abs;
              acc   <= {{WIDTH{1'b0}}, b_abs};
              state <= MUL;
              busy  <= 1'b1;
            end else if (srcb != '0) begin
              opd   <= b_abs;
              acc   <= {{WIDTH{1'b0}}, a_abs};
              rem   <= '0;
              state <= DIV;
              busy  <= 1'b1;
            end else begin
              state   <= DONE;
              done    <= 1'b1;
              divzero <= 1'b1;
            end
          end
        end
        MUL: begin
          cnt <= cnt + 1'b1;
          acc <= mul_next;
          if (cnt == LAST) begin
            hi    <= prod[2*WIDTH-1:WIDTH];
            lo    <= prod[WIDTH-1:0];
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DIV: begin
          cnt              <= cnt + 1'b1;
          acc[WIDTH-1:0]   <= div_quo;
          rem              <= div_rem;
          if (cnt == LAST) begin
            hi    <= rem_fix;
            lo    <= quo_fix;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with hand-computed results.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        divop = 1'b0;
  logic        signedop = 1'b0;
  logic [31:0] srca = '0;
  logic [31:0] srcb = '0;
  logic        hiwrite = 1'b0;
  logic        lowrite = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] hi, lo;
  logic        busy, done, divzero;

  int checks = 0;
  int failures = 0;
  int n;
  int dcount;

  muldiv_unit #(.WIDTH(32), .ITER(32)) dut (
    .clk(clk), .reset(reset), .start(start), .divop(divop), .signedop(signedop),
    .srca(srca), .srcb(srcb), .hiwrite(hiwrite), .lowrite(lowrite), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .divzero(divzero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present an operation for one edge (the launch edge), then drop start 1 ns later
  task automatic launch(input logic d, input logic s, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; divop = d; signedop = s; srca = a; srcb = b;
    @(posedge clk); #1;
    start = 1'b0; srca = $urandom; srcb = $urandom;
  endtask

  // Edges from now until done is observed high; 99 if it never arrives
  task automatic wait_done(output int edges);
    edges = 99;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        edges = k;
        break;
      end
    end
  endtask

  initial begin
    #12;
    check("rst_hi", {32'h0, hi}, 64'h0);
    check("rst_lo", {32'h0, lo}, 64'h0);
    check("rst_flags", {61'h0, busy, done, divzero}, 64'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: MULTU max x max
    launch(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("t1_busy", {63'h0, busy}, 64'h1);
    wait_done(n);
    check("t1_lat", 64'(n), 64'd32);
    check("t1_res", {hi, lo}, 64'hFFFFFFFE_00000001);
    check("t1_dz", {63'h0, divzero}, 64'h0);

    // 2: MULT -3 x 7, then DIVU 100/7 launched in the DONE cycle
    launch(1'b0, 1'b1, 32'hFFFFFFFD, 32'h7);
    wait_done(n);
    check("t2_lat", 64'(n), 64'd32);
    check("t2_res", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    launch(1'b1, 1'b0, 32'd100, 32'd7);
    check("t2_b2b_busy", {63'h0, busy}, 64'h1);
    wait_done(n);
    check("t2_div_lat", 64'(n), 64'd32);
    check("t2_div_res", {hi, lo}, {32'd2, 32'd14});
    @(posedge clk); #1;
    check("t2_done_1cyc", {63'h0, done}, 64'h0);

    // 3: signed divides incl. the wrapping corner; one large unsigned divide
    launch(1'b1, 1'b1, 32'hFFFFFFF9, 32'h2);
    wait_done(n);
    check("t3_neg_div", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    launch(1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF);
    wait_done(n);
    check("t3_wrap_div", {hi, lo}, 64'h00000000_80000000);
    launch(1'b1, 1'b0, 32'hFFFFFFFF, 32'h10);
    wait_done(n);
    check("t3_divu_big", {hi, lo}, 64'h0000000F_0FFFFFFF);

    // 4: MTHI/MTLO then divide by zero
    @(posedge clk); #1;
    hiwrite = 1'b1; wdata = 32'h12345678;
    @(posedge clk); #1;
    hiwrite = 1'b0; lowrite = 1'b1; wdata = 32'h9ABCDEF0;
    @(posedge clk); #1;
    lowrite = 1'b0;
    check("t4_mt", {hi, lo}, 64'h12345678_9ABCDEF0);
    launch(1'b1, 1'b1, 32'd55, 32'd0);
    check("t4_dz_flags", {61'h0, busy, done, divzero}, 64'h3);
    check("t4_dz_keep", {hi, lo}, 64'h12345678_9ABCDEF0);
    @(posedge clk); #1;
    check("t4_dz_after", {61'h0, busy, done, divzero}, 64'h0);

    // 5: start and MTHI while busy are ignored
    launch(1'b0, 1'b1, 32'h00001234, 32'hFFFFFFFF);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; divop = 1'b1; hiwrite = 1'b1; wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    start = 1'b0; divop = 1'b0; hiwrite = 1'b0;
    check("t5_still_busy", {63'h0, busy}, 64'h1);
    wait_done(n);
    check("t5_lat", 64'(n), 64'd26);
    check("t5_res", {hi, lo}, 64'hFFFFFFFF_FFFFEDCC);

    // 6: async reset mid-multiply
    launch(1'b0, 1'b0, 32'h0000FFFF, 32'h0000FFFF);
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("t6_rst_hilo", {hi, lo}, 64'h0);
    check("t6_rst_flags", {61'h0, busy, done, divzero}, 64'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    dcount = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    check("t6_no_done", 64'(dcount), 64'd0);
    launch(1'b0, 1'b0, 32'd3, 32'd5);
    wait_done(n);
    check("t6_lat", 64'(n), 64'd32);
    check("t6_res", {hi, lo}, 64'h00000000_0000000F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit with the architectural HI/LO registers. It sits in the Execute stage beside the ALU and consumes srcA/srcB from the datapath's E-stage operand muxes. It supplies HI/LO to the W-stage mfhi/mflo mux and drives a busy flag to the hazard unit. MULT/MULTU/DIV/DIVU take 32 iteration cycles; MTHI/MTLO write HI/LO directly.

Parameters:
WIDTH, 32, operand and HI/LO width
ITER, 32, iteration count per operation; must equal WIDTH

Ports:
clk       input   1      rising-edge clock
reset     input   1      asynchronous, active-high; clears all state
start     input   1      launch mult/div; sampled only in IDLE or DONE
divop     input   1      1 = divide, 0 = multiply
signedop  input   1      1 = signed (MULT/DIV), 0 = unsigned
srca      input   WIDTH  multiplicand / dividend
srcb      input   WIDTH  multiplier / divisor
hiwrite   input   1      MTHI: HI <= wdata
lowrite   input   1      MTLO: LO <= wdata
wdata     input   WIDTH  direct-write data
hi        output  WIDTH  HI register
lo        output  WIDTH  LO register
busy      output  1      operation in progress; hazard unit stalls F/D/E on busy
done      output  1      one-cycle pulse; result is valid in HI/LO
divzero   output  1      pulses with done when a divide had srcb == 0

Behaviour:
- Reset (async, any state): state=IDLE, hi=lo=0, busy=done=divzero=0, counter=0, internal operand regs=0.
- States: IDLE, MUL, DIV, DONE. busy=1 only in MUL/DIV. done=1 only in DONE.
- Launch: start=1 in IDLE or DONE latches |srca| and |srcb|, counter=0, and result-sign bits.
  - Absolute values apply only when signedop=1; otherwise raw values.
  - Result sign: product/quotient sign = sa^sb; remainder sign = sa.
  - Next state is MUL if divop=0. Next state is DIV if divop=1 and srcb!=0.
- Divide by zero: divop=1 and srcb==0 goes to DONE on the launch edge. HI/LO are unchanged, and divzero=1 during the DONE cycle.
- MUL: radix-2 shift-add, one bit per edge on a 2*WIDTH accumulator.
- DIV: restoring division, one quotient bit per edge, with a WIDTH+1 remainder.
- Counter:
  - Increments every MUL/DIV edge.
  - On the edge with counter==ITER-1, the sign-corrected result is written: HI=upper product or remainder, LO=lower product or quotient. State goes to DONE.
  - The launch edge is edge 0. The result is written on edge 32, and done is high during the cycle after edge 32.
- DONE lasts one cycle, then goes to IDLE. A start seen in DONE relaunches directly (back-to-back ops).
- start while busy: ignored. The hazard unit guarantees the instruction is held, so it re-presents once busy drops.
- hiwrite/lowrite:
  - Take effect on the next edge in IDLE or DONE. They are ignored while busy.
  - Both may be set together.
  - If issued on the same edge as start, the write lands; the later result overwrites it, and a div-by-zero leaves the written value.
- Arithmetic: results wrap naturally.
  - Signed 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - Multiply never overflows (64-bit product).
- Operands and control are ignored after launch; srca/srcb may change freely while busy.
- An async reset mid-operation aborts immediately. HI/LO clear to 0 and no done pulse occurs.

Test Plan:
1. MULTU 0xFFFFFFFF×0xFFFFFFFF -> busy rises after launch edge; done in cycle after edge 32; HI=0xFFFFFFFE, LO=0x00000001.
2. MULT signed 0xFFFFFFFD (-3) × 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; then back-to-back start in DONE with DIVU 100/7 -> HI=2, LO=14 after another 32 edges, no idle cycle.
3. DIV signed 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
4. MTHI 0x12345678, MTLO 0x9ABCDEF0 in IDLE, then DIV x/0 -> done and divzero high the cycle after launch, busy never set, HI/LO keep 0x12345678/0x9ABCDEF0.
5. During MULT busy, pulse start (DIV) and hiwrite 0xDEADBEEF -> both ignored; the MULT result is correct; HI ≠ 0xDEADBEEF.
6. Assert reset asynchronously mid-MULT (after edge 10, between clock edges) -> hi=lo=0, busy=0 immediately, no done pulse; a new MULTU 3×5 then gives LO=15, HI=0.
